// File: rtl/avst_pkt_arbiter_if.sv
// avst_pkt_arbiter_if: Avalon-ST beat bundle (data, end-of-packet, valid, ready)
//   master: drives data/eop/valid, receives ready
//   slave : receives data/eop/valid, drives ready
// The Avalon end signal is named eop because end is a reserved word.
interface avst_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              eop;
  logic              valid;
  logic              ready;
  modport master(output data, eop, valid, input ready);
  modport slave(input data, eop, valid, output ready);
endinterface

// File: rtl/avst_pkt_arbiter.sv
// avst_pkt_arbiter: packet-level round-robin share of one Avalon-ST adder between two requesters
//   clk, reset : clock, asynchronous active-high reset
//   s0, s1     : request streams in (slave)
//   m          : request stream to the adder (master)
//   r          : response stream from the adder (slave)
//   d0, d1     : response streams back to each requester (master)
//   AVST_ARB_STATS_EN adds pkt_cnt0/pkt_cnt1 (completed request packets) and stall_full.
module avst_pkt_arbiter #(
  parameter int DATA_W    = 8,
  parameter int TAG_DEPTH = 4
) (
  input logic    clk,
  input logic    reset,
  avst_if.slave  s0,
  avst_if.slave  s1,
  avst_if.master m,
  avst_if.slave  r,
  avst_if.master d0,
  avst_if.master d1
`ifdef AVST_ARB_STATS_EN
  ,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic        stall_full
`endif
);
  localparam int PW = $clog2(TAG_DEPTH);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nx;
  logic rr;
  logic [TAG_DEPTH-1:0] tags;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] cnt;
  logic [DATA_W-1:0] fwd_data;
  logic full, empty, any_req, grant_tag, push, pop, done0, done1, head;
  assign full = cnt == (PW+1)'(TAG_DEPTH);
  assign empty = cnt == '0;
  assign any_req = s0.valid | s1.valid;
  // rr holds the requester served last, so s1 wins a tie only when s0 went last
  assign grant_tag = s1.valid & (~s0.valid | ~rr);
  assign push = state == IDLE && !full && any_req;
  assign done0 = state == GNT0 && s0.valid && m.ready && s0.eop;
  assign done1 = state == GNT1 && s1.valid && m.ready && s1.eop;
  assign head = tags[rd_ptr];
  assign pop = r.valid && r.ready && r.eop;
  always_comb begin
    state_nx = state;
    fwd_data = s0.data;
    m.eop = s0.eop;
    m.valid = 1'b0;
    s0.ready = 1'b0;
    s1.ready = 1'b0;
    case (state)
      IDLE: state_nx = push ? (grant_tag ? GNT1 : GNT0) : IDLE;
      GNT0: begin
        m.valid = s0.valid;
        s0.ready = m.ready;
        state_nx = done0 ? IDLE : GNT0;
      end
      GNT1: begin
        fwd_data = s1.data;
        m.eop = s1.eop;
        m.valid = s1.valid;
        s1.ready = m.ready;
        state_nx = done1 ? IDLE : GNT1;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign m.data = fwd_data;
  // Responses follow the oldest outstanding tag; nothing is routed while no tag is held
  assign d0.data = r.data;
  assign d0.eop = r.eop;
  assign d0.valid = !empty && !head && r.valid;
  assign d1.data = r.data;
  assign d1.eop = r.eop;
  assign d1.valid = !empty && head && r.valid;
  assign r.ready = !empty && (head ? d1.ready : d0.ready);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (done0 || done1) rr <= done1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= grant_tag;
  end
`ifdef AVST_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (done0) pkt_cnt0 <= pkt_cnt0 + 16'd1;
      if (done1) pkt_cnt1 <= pkt_cnt1 + 16'd1;
    end
  end
  assign stall_full = state == IDLE && full && any_req;
`endif
endmodule

// File: tb/tb_avst_pkt_arbiter.sv
// tb_avst_pkt_arbiter: scoreboard bench with a behavioural adder that answers each beat with data+1
module tb_avst_pkt_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  avst_if #(.DATA_W(8)) s0_if ();
  avst_if #(.DATA_W(8)) s1_if ();
  avst_if #(.DATA_W(8)) m_if ();
  avst_if #(.DATA_W(8)) r_if ();
  avst_if #(.DATA_W(8)) d0_if ();
  avst_if #(.DATA_W(8)) d1_if ();
`ifdef AVST_ARB_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic stall_full;
`endif
  avst_pkt_arbiter #(.DATA_W(8), .TAG_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .s0(s0_if),
    .s1(s1_if),
    .m(m_if),
    .r(r_if),
    .d0(d0_if),
    .d1(d1_if)
`ifdef AVST_ARB_STATS_EN
    ,
    .pkt_cnt0(pkt_cnt0),
    .pkt_cnt1(pkt_cnt1),
    .stall_full(stall_full)
`endif
  );
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_m[$], exp_d0[$], exp_d1[$], aq[$];
  logic tm = 1'b0, tr = 1'b0;
  logic [8:0] mm;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    tm = !reset && m_if.valid && m_if.ready;
    tr = !reset && r_if.valid && r_if.ready;
    mm = {m_if.eop, m_if.data};
    if (tm) begin
      if (exp_m.size() == 0) chk("m_unexp", 32'(exp_m.size()), 1);
      else chk("m_beat", 32'(mm), 32'(exp_m.pop_front()));
    end
    if (!reset && d0_if.valid && d0_if.ready) begin
      if (exp_d0.size() == 0) chk("d0_unexp", 32'(exp_d0.size()), 1);
      else chk("d0_beat", 32'({d0_if.eop, d0_if.data}), 32'(exp_d0.pop_front()));
    end
    if (!reset && d1_if.valid && d1_if.ready) begin
      if (exp_d1.size() == 0) chk("d1_unexp", 32'(exp_d1.size()), 1);
      else chk("d1_beat", 32'({d1_if.eop, d1_if.data}), 32'(exp_d1.pop_front()));
    end
  end
  always @(posedge clk) begin
    #1;
    if (reset) aq.delete();
    else begin
      if (tr) void'(aq.pop_front());
      if (tm) aq.push_back(mm);
    end
    r_if.valid = aq.size() != 0;
    r_if.data = aq.size() != 0 ? aq[0][7:0] + 8'd1 : 8'h00;
    r_if.eop = aq.size() != 0 ? aq[0][8] : 1'b0;
  end
  task automatic drv(input bit s, input bit v, input logic [7:0] d, input bit e);
    if (s) begin
      s1_if.valid = v;
      s1_if.data = d;
      s1_if.eop = e;
    end else begin
      s0_if.valid = v;
      s0_if.data = d;
      s0_if.eop = e;
    end
  endtask
  task automatic exp_pkt(input bit s, input logic [7:0] b, input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = b + 8'(i);
      exp_m.push_back({i == n - 1, d});
      if (s) exp_d1.push_back({i == n - 1, 8'(d + 8'd1)});
      else exp_d0.push_back({i == n - 1, 8'(d + 8'd1)});
    end
  endtask
  task automatic send(input bit s, input logic [7:0] b, input int n, output int w0);
    logic rd;
    int w;
    w0 = 0;
    for (int i = 0; i < n; i++) begin
      drv(s, 1'b1, b + 8'(i), i == n - 1);
      w = 0;
      do begin
        @(negedge clk);
        rd = s ? s1_if.ready : s0_if.ready;
        if (!rd) w++;
        @(posedge clk);
      end while (!rd && w < 300);
      if (i == 0) w0 = w;
      if (!rd) chk("send_timeout", 32'(rd), 1);
      #1;
    end
    drv(s, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic drain();
    int t;
    t = 0;
    while ((exp_m.size() + exp_d0.size() + exp_d1.size()) != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 32'(exp_m.size() + exp_d0.size() + exp_d1.size()), 0);
    repeat (2) @(negedge clk);
    chk("fifo_empty", 32'(r_if.ready), 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal;
  end
  initial begin
    int wa, wb, t;
    drv(0, 1'b1, 8'h00, 1'b0);
    drv(1, 1'b1, 8'h00, 1'b0);
    m_if.ready = 1'b1;
    d0_if.ready = 1'b1;
    d1_if.ready = 1'b1;
    r_if.valid = 1'b0;
    r_if.data = 8'h00;
    r_if.eop = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_out", 32'({s0_if.ready, s1_if.ready, m_if.valid, r_if.ready, d0_if.valid, d1_if.valid}), 0);
    drv(0, 1'b0, 8'h00, 1'b0);
    drv(1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_pkt(0, 8'h01, 3);
    send(0, 8'h01, 3, wa);
    chk("idle_gap", 32'(wa), 1);
    drain();
    d1_if.ready = 1'b0;
    exp_pkt(1, 8'h30, 4);
    fork
      send(1, 8'h30, 4, wa);
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk);
          #1 m_if.ready = ~m_if.ready;
          @(negedge clk);
          if (m_if.valid) chk("bp_mirror", 32'(s1_if.ready), 32'(m_if.ready));
        end
        @(posedge clk);
        #1 m_if.ready = 1'b1;
      end
    join
    repeat (5) begin
      @(negedge clk);
      chk("r_hold", 32'(r_if.ready), 0);
      chk("r_pend", 32'(r_if.valid), 1);
    end
    @(posedge clk);
    #1 d1_if.ready = 1'b1;
    drain();
    exp_pkt(0, 8'h10, 2);
    exp_pkt(1, 8'h20, 2);
    exp_pkt(0, 8'h10, 2);
    exp_pkt(1, 8'h20, 2);
    fork
      begin
        send(0, 8'h10, 2, wa);
        send(0, 8'h10, 2, wa);
      end
      begin
        send(1, 8'h20, 2, wb);
        send(1, 8'h20, 2, wb);
      end
    join
    drain();
    d0_if.ready = 1'b0;
    d1_if.ready = 1'b0;
    for (int k = 0; k < 5; k++) exp_pkt(0, 8'h40 + 8'(2 * k), 1);
    fork
      begin
        for (int k = 0; k < 5; k++) send(0, 8'h40 + 8'(2 * k), 1, wa);
      end
      begin
        t = 0;
        while (exp_m.size() != 1 && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("full_grants", 32'(exp_m.size()), 1);
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("full_block", 32'(s0_if.ready), 0);
`ifdef AVST_ARB_STATS_EN
          chk("stall_full", 32'(stall_full), 1);
`endif
        end
        @(posedge clk);
        #1;
        d0_if.ready = 1'b1;
        d1_if.ready = 1'b1;
      end
    join
    drain();
    d1_if.ready = 1'b0;
    exp_pkt(1, 8'h50, 1);
    send(1, 8'h50, 1, wa);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!r_if.valid && t < 50);
    chk("pp_resp", 32'(r_if.valid), 1);
    @(posedge clk);
    #1 d1_if.ready = 1'b1;
    exp_pkt(0, 8'h60, 1);
    fork
      send(0, 8'h60, 1, wa);
      begin
        @(posedge clk);
        @(negedge clk);
        chk("pp_occ", 32'(r_if.ready), 1);
        chk("pp_grant", 32'(s0_if.ready), 1);
      end
    join
    drain();
`ifdef AVST_ARB_STATS_EN
    chk("cnt0", 32'(pkt_cnt0), 9);
    chk("cnt1", 32'(pkt_cnt1), 4);
`endif
    exp_pkt(1, 8'h70, 4);
    drv(1, 1'b1, 8'h70, 1'b0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s1_if.ready && t < 20);
    @(posedge clk);
    #1 drv(1, 1'b1, 8'h71, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_async", 32'({s0_if.ready, s1_if.ready, m_if.valid, r_if.ready, d0_if.valid, d1_if.valid}), 0);
    drv(1, 1'b0, 8'h00, 1'b0);
    exp_m.delete();
    exp_d0.delete();
    exp_d1.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
`ifdef AVST_ARB_STATS_EN
    chk("cnt0_rst", 32'(pkt_cnt0), 0);
    chk("cnt1_rst", 32'(pkt_cnt1), 0);
`endif
    exp_pkt(0, 8'h80, 1);
    exp_pkt(1, 8'h90, 1);
    fork
      send(0, 8'h80, 1, wa);
      send(1, 8'h90, 1, wb);
    join
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
